// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, control-bundle encodings and the ID control struct.
package core_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    // ALU op classes; the EX-side ALU control refines REG/IMM using funct3/funct7
    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
    localparam logic [1:0] ALU_OP_REG    = 2'd2;
    localparam logic [1:0] ALU_OP_IMM    = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       branch;
        logic       jump;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic [1:0] wb_sel;
    } id_ctrl_t;

endpackage

// File: rtl/id_hazard_unit.sv
// Load-use hazard detection between the incoming instruction and the ID/EX load.
module id_hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [6:0]                opcode,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic                      in_valid,
    input  logic                      ex_valid,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      hz
);

    logic uses_rs1;
    logic uses_rs2;

    assign uses_rs1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    assign hz = in_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));

endmodule

// File: rtl/immediate_generator.sv
// Sign-extended immediate extraction for the RV32I formats.
module immediate_generator
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    input  imm_sel_e              imm_sel,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_sel)
            ImmI:    imm32 = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmU:    imm32 = {instr[31:12], 12'b0};
            ImmJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                              1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/main_control_unit.sv
// Main control decoder: opcode to control bundle, immediate type and illegal flag.
module main_control_unit
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    output id_ctrl_t   ctrl,
    output imm_sel_e   imm_sel,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        imm_sel = ImmNone;
        illegal = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl.alu_src_a = SRC_A_ZERO;
                ctrl.alu_src_b = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_sel        = ImmU;
            end
            OP_AUIPC: begin
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_sel        = ImmU;
            end
            OP_JAL: begin
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                imm_sel        = ImmJ;
            end
            OP_JALR: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                imm_sel        = ImmI;
            end
            OP_BRANCH: begin
                ctrl.alu_op = ALU_OP_BRANCH;
                ctrl.branch = 1'b1;
                imm_sel     = ImmB;
            end
            OP_LOAD: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_MEM;
                imm_sel        = ImmI;
            end
            OP_STORE: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.mem_write = 1'b1;
                imm_sel        = ImmS;
            end
            OP_IMM: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_op    = ALU_OP_IMM;
                ctrl.reg_write = 1'b1;
                imm_sel        = ImmI;
            end
            OP_REG: begin
                ctrl.alu_op    = ALU_OP_REG;
                ctrl.reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with hard-wired x0 and optional WB->read bypass.
module register_file #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned BYPASS_EN      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic [DATA_WIDTH-1:0]     rdata2
);

    localparam int unsigned Depth = 2 ** REG_ADDR_WIDTH;
    localparam bit Bypass = (BYPASS_EN != 0);

    logic [DATA_WIDTH-1:0] regs_q [Depth];
    logic                  write_en;

    function automatic logic in_range(input logic [REG_ADDR_WIDTH-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    assign write_en = we && (waddr != '0) && in_range(waddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
        end else if (write_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0 || !in_range(raddr1)) ? '0 :
                    (Bypass && write_en && waddr == raddr1) ? wdata : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0 || !in_range(raddr2)) ? '0 :
                    (Bypass && write_en && waddr == raddr2) ? wdata : regs_q[raddr2];

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: decode, register read, load-use bubble and the ID/EX register.
module id_stage_pipe
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned BYPASS_EN       = 1,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_pc,
    input  logic [DATA_WIDTH-1:0]      in_pc_plus4,
    input  logic [31:0]                in_instr,
    input  logic                       wb_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0]  wb_addr,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output id_ctrl_t                   out_ctrl,
    output logic [DATA_WIDTH-1:0]      out_pc,
    output logic [DATA_WIDTH-1:0]      out_pc_plus4,
    output logic [DATA_WIDTH-1:0]      out_imm,
    output logic [DATA_WIDTH-1:0]      out_rs1_data,
    output logic [DATA_WIDTH-1:0]      out_rs2_data,
    output logic [REG_ADDR_WIDTH-1:0]  out_rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0]  out_rs2_addr,
    output logic [REG_ADDR_WIDTH-1:0]  out_rd_addr,
    output logic                       out_illegal,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    id_ctrl_t                  dec_ctrl;
    imm_sel_e                  imm_sel;
    logic                      dec_illegal, hz, advance;
    logic [DATA_WIDTH-1:0]     dec_imm, rs1_data, rs2_data;
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;

    assign rs1 = REG_ADDR_WIDTH'(in_instr[19:15]);
    assign rs2 = REG_ADDR_WIDTH'(in_instr[24:20]);
    assign rd  = REG_ADDR_WIDTH'(in_instr[11:7]);

    main_control_unit u_ctrl (
        .opcode  (in_instr[6:0]),
        .ctrl    (dec_ctrl),
        .imm_sel (imm_sel),
        .illegal (dec_illegal)
    );

    immediate_generator #(.DATA_WIDTH(DATA_WIDTH)) u_imm (
        .instr   (in_instr),
        .imm_sel (imm_sel),
        .imm     (dec_imm)
    );

    register_file #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_REGS       (NUM_REGS),
        .BYPASS_EN      (BYPASS_EN)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_regwrite),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    id_hazard_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hz (
        .opcode      (in_instr[6:0]),
        .rs1         (rs1),
        .rs2         (rs2),
        .in_valid    (in_valid),
        .ex_valid    (out_valid),
        .ex_mem_read (out_ctrl.mem_read),
        .ex_rd       (out_rd_addr),
        .hz          (hz)
    );

    assign advance  = out_ready || !out_valid;
    assign in_ready = flush || (advance && !hz);

    // Flush and bubble only clear valid/ctrl; the datapath fields are don't-care when invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_ctrl     <= '0;
            out_pc       <= '0;
            out_pc_plus4 <= '0;
            out_imm      <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rs1_addr <= '0;
            out_rs2_addr <= '0;
            out_rd_addr  <= '0;
            out_illegal  <= 1'b0;
            stall_cnt    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (advance && hz) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            if (!(&stall_cnt)) stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
        end else if (advance) begin
            out_valid    <= in_valid;
            out_ctrl     <= in_valid ? dec_ctrl : '0;
            out_pc       <= in_pc;
            out_pc_plus4 <= in_pc_plus4;
            out_imm      <= dec_imm;
            out_rs1_data <= rs1_data;
            out_rs2_data <= rs2_data;
            out_rs1_addr <= rs1;
            out_rs2_addr <= rs2;
            out_rd_addr  <= rd;
            out_illegal  <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus a randomized run against a cycle model.
module tb_id_stage_pipe;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, flush, wb_regwrite;
    logic [31:0] in_pc, in_pc_plus4, in_instr, wb_data;
    logic [4:0]  wb_addr;

    logic        in_ready, out_valid, out_illegal;
    id_ctrl_t    out_ctrl;
    logic [31:0] out_pc, out_pc_plus4, out_imm, out_rs1_data, out_rs2_data;
    logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [15:0] stall_cnt;

    logic        nb_in_ready, nb_out_valid, nb_out_illegal;
    id_ctrl_t    nb_out_ctrl;
    logic [31:0] nb_out_pc, nb_out_pc_plus4, nb_out_imm, nb_out_rs1_data, nb_out_rs2_data;
    logic [4:0]  nb_out_rs1_addr, nb_out_rs2_addr, nb_out_rd_addr;
    logic [1:0]  nb_stall_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_pc_plus4(in_pc_plus4), .in_instr(in_instr), .wb_regwrite(wb_regwrite),
        .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .out_imm(out_imm), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
        .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    // No bypass and a 2-bit stall counter so saturation is reachable.
    id_stage_pipe #(.BYPASS_EN(0), .STALL_CNT_WIDTH(2)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .in_pc(in_pc),
        .in_pc_plus4(in_pc_plus4), .in_instr(in_instr), .wb_regwrite(wb_regwrite),
        .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .out_valid(nb_out_valid),
        .out_ready(out_ready), .out_ctrl(nb_out_ctrl), .out_pc(nb_out_pc),
        .out_pc_plus4(nb_out_pc_plus4), .out_imm(nb_out_imm), .out_rs1_data(nb_out_rs1_data),
        .out_rs2_data(nb_out_rs2_data), .out_rs1_addr(nb_out_rs1_addr),
        .out_rs2_addr(nb_out_rs2_addr), .out_rd_addr(nb_out_rd_addr),
        .out_illegal(nb_out_illegal), .stall_cnt(nb_stall_cnt)
    );

    // Reference model state
    bit          m_valid, m_ill, m_has_imm;
    id_ctrl_t    m_ctrl;
    logic [31:0] m_pc, m_pc4, m_imm, m_rs1d, m_rs2d, m_rs1d_nb;
    logic [4:0]  m_rs1a, m_rs2a, m_rd;
    int          m_stall, m_stall_nb;
    logic [31:0] m_regs [32];

    function automatic bit op_legal(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                          OP_IMM, OP_REG};
    endfunction

    function automatic id_ctrl_t exp_ctrl(input logic [6:0] op);
        id_ctrl_t c = '0;
        if (!op_legal(op)) return c;
        c.reg_write = !(op inside {OP_BRANCH, OP_STORE});
        c.mem_read  = (op == OP_LOAD);
        c.mem_write = (op == OP_STORE);
        c.branch    = (op == OP_BRANCH);
        c.jump      = op inside {OP_JAL, OP_JALR};
        c.alu_src_a = (op == OP_LUI) ? SRC_A_ZERO :
                      (op inside {OP_AUIPC, OP_JAL}) ? SRC_A_PC : SRC_A_RS1;
        c.alu_src_b = !(op inside {OP_REG, OP_BRANCH});
        c.alu_op    = (op == OP_REG) ? ALU_OP_REG : (op == OP_IMM) ? ALU_OP_IMM :
                      (op == OP_BRANCH) ? ALU_OP_BRANCH : ALU_OP_ADD;
        c.wb_sel    = (op == OP_LOAD) ? WB_MEM : c.jump ? WB_PC4 : WB_ALU;
        return c;
    endfunction

    function automatic bit exp_imm(input logic [31:0] i, output logic [31:0] v);
        logic [6:0] op = i[6:0];
        v = '0;
        if (op inside {OP_LOAD, OP_IMM, OP_JALR}) v = {{20{i[31]}}, i[31:20]};
        else if (op == OP_STORE) v = {{20{i[31]}}, i[31:25], i[11:7]};
        else if (op == OP_BRANCH) v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        else if (op inside {OP_LUI, OP_AUIPC}) v = {i[31:12], 12'b0};
        else if (op == OP_JAL) v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        else return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && wb_regwrite && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit model_hz();
        logic [6:0] op = in_instr[6:0];
        bit u1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
        bit u2 = op inside {OP_REG, OP_STORE, OP_BRANCH};
        return in_valid && m_valid && m_ctrl.mem_read && m_rd != 0 &&
               ((u1 && in_instr[19:15] == m_rd) || (u2 && in_instr[24:20] == m_rd));
    endfunction

    function automatic bit model_in_ready();
        return flush || ((out_ready || !m_valid) && !model_hz());
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ill = 0; m_has_imm = 0; m_ctrl = '0;
        m_pc = 0; m_pc4 = 0; m_imm = 0; m_rs1d = 0; m_rs2d = 0; m_rs1d_nb = 0;
        m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_stall = 0; m_stall_nb = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    // One clock: predict from stable inputs, take the edge, then update the model.
    task automatic cycle();
        bit hz = model_hz();
        bit adv = out_ready || !m_valid;
        logic [31:0] r1 = rd_reg(in_instr[19:15], 1'b1);
        logic [31:0] r2 = rd_reg(in_instr[24:20], 1'b1);
        logic [31:0] r1nb = rd_reg(in_instr[19:15], 1'b0);
        logic [31:0] iv;
        bit hi = exp_imm(in_instr, iv);
        @(posedge clk);
        if (flush) begin
            m_valid = 0; m_ctrl = '0;
        end else if (adv && hz) begin
            m_valid = 0; m_ctrl = '0;
            if (m_stall < 65535) m_stall++;
            if (m_stall_nb < 3) m_stall_nb++;
        end else if (adv) begin
            m_valid = in_valid;
            m_ctrl = in_valid ? exp_ctrl(in_instr[6:0]) : '0;
            m_pc = in_pc; m_pc4 = in_pc_plus4; m_imm = iv; m_has_imm = hi;
            m_rs1d = r1; m_rs2d = r2; m_rs1d_nb = r1nb;
            m_rs1a = in_instr[19:15]; m_rs2a = in_instr[24:20]; m_rd = in_instr[11:7];
            m_ill = !op_legal(in_instr[6:0]);
        end
        if (wb_regwrite && wb_addr != 0) m_regs[wb_addr] = wb_data;
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, rs1, rd);
        return {7'b0, rs2, rs1, 3'b000, rd, OP_REG};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic set_in(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1; in_instr = instr; in_pc = pc; in_pc_plus4 = pc + 4;
    endtask

    task automatic idle(input int n);
        in_valid = 0; out_ready = 1; flush = 0; wb_regwrite = 0;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; out_ready = 1; flush = 0; wb_regwrite = 0;
        wb_addr = 0; wb_data = 0; in_instr = 0; in_pc = 0; in_pc_plus4 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", out_valid); end
        total++; if (out_ctrl !== '0) begin bad++; $display("FAIL rst_ctrl got=%0h want=0", out_ctrl); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", stall_cnt); end
        total++; if ({out_pc, out_imm, out_rs1_data, out_rd_addr, out_illegal} !== '0) begin
            bad++; $display("FAIL rst_fields got=%0h/%0h/%0h/%0h/%0b want=0", out_pc, out_imm, out_rs1_data, out_rd_addr, out_illegal); end
        rst = 0;
        set_in(enc_r(5'd6, 5'd5, 5'd4), 32'h40);
        cycle();
        total++; if ({out_rs1_data, out_rs2_data} !== 64'h0) begin
            bad++; $display("FAIL rst_regfile got=%0h/%0h want=0/0", out_rs1_data, out_rs2_data); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        out_ready = 1;
        set_in(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM), 32'h100);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%0b want=1", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b1 || out_rd_addr !== 5'd1 || out_imm !== 32'd5) begin
            bad++; $display("FAIL b2b_first got=v%0b rd%0d imm%0h want=v1 rd1 imm5", out_valid, out_rd_addr, out_imm); end
        set_in(enc_r(5'd1, 5'd1, 5'd2), 32'h104);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%0b want=1", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b1 || out_rs1_addr !== 5'd1 || out_ctrl !== exp_ctrl(OP_REG)) begin
            bad++; $display("FAIL b2b_second got=v%0b rs1=%0d ctrl=%0h want=v1 rs1=1 ctrl=%0h", out_valid, out_rs1_addr, out_ctrl, exp_ctrl(OP_REG)); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL b2b_stall got=%0d want=0", stall_cnt); end
        idle(1);
    endtask

    task automatic test_load_use();
        out_ready = 1;
        set_in(enc_i(12'd0, 5'd0, 3'b010, 5'd3, OP_LOAD), 32'h200);
        cycle();
        set_in(enc_r(5'd0, 5'd3, 5'd4), 32'h204);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_ready_stall got=%0b want=0", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            bad++; $display("FAIL lu_bubble got=v%0b ctrl=%0h want=v0 ctrl=0", out_valid, out_ctrl); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall got=%0d want=1", stall_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_ready_after got=%0b want=1", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b1 || out_rd_addr !== 5'd4 || out_pc !== 32'h204) begin
            bad++; $display("FAIL lu_issue got=v%0b rd%0d pc%0h want=v1 rd4 pc204", out_valid, out_rd_addr, out_pc); end
        idle(1);
        // Load to x0 never creates a dependency
        set_in(enc_i(12'd0, 5'd0, 3'b010, 5'd0, OP_LOAD), 32'h300);
        cycle();
        set_in(enc_r(5'd0, 5'd0, 5'd4), 32'h304);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%0b want=1", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b1 || stall_cnt !== 16'd1) begin
            bad++; $display("FAIL x0_nostall got=v%0b stall%0d want=v1 stall1", out_valid, stall_cnt); end
        idle(1);
    endtask

    task automatic test_bypass();
        wb_regwrite = 1; wb_addr = 5'd7; wb_data = 32'h11111111;
        cycle();
        set_in(enc_r(5'd0, 5'd7, 5'd8), 32'h400);
        wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
        cycle();
        wb_regwrite = 0;
        total++; if (out_rs1_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL bypass_on got=%0h want=deadbeef", out_rs1_data); end
        total++; if (nb_out_rs1_data !== 32'h11111111) begin
            bad++; $display("FAIL bypass_off got=%0h want=11111111", nb_out_rs1_data); end
        set_in(enc_r(5'd7, 5'd7, 5'd9), 32'h404);
        cycle();
        total++; if (nb_out_rs1_data !== 32'hDEADBEEF || nb_out_rs2_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL bypass_written got=%0h/%0h want=deadbeef", nb_out_rs1_data, nb_out_rs2_data); end
        idle(1);
    endtask

    task automatic test_backpressure_flush();
        set_in(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM), 32'h500);
        cycle();
        out_ready = 0;
        set_in(enc_r(5'd1, 5'd1, 5'd2), 32'h504);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%0b want=0", k, in_ready); end
            cycle();
            total++; if (out_valid !== 1'b1 || out_pc !== 32'h500 || out_rd_addr !== 5'd1 || out_imm !== 32'd5) begin
                bad++; $display("FAIL bp_hold%0d got=v%0b pc%0h rd%0d imm%0h want=v1 pc500 rd1 imm5", k, out_valid, out_pc, out_rd_addr, out_imm); end
        end
        flush = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b want=1", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            bad++; $display("FAIL flush_clear got=v%0b ctrl=%0h want=v0 ctrl=0", out_valid, out_ctrl); end
        idle(1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] r = $urandom;
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM,
                OP_REG, OP_LOAD, OP_LOAD, 7'h7f};
        return {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:12],
                5'($urandom_range(0, 3)), ops[$urandom_range(0, 11)]};
    endfunction

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = rand_instr();
            in_pc = $urandom; in_pc_plus4 = in_pc + 4;
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            wb_regwrite = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            #1;
            total++; if (in_ready !== model_in_ready()) begin
                bad++; $display("FAIL rnd_in_ready k=%0d got=%0b want=%0b", k, in_ready, model_in_ready()); end
            cycle();
            total++; if (out_valid !== m_valid || out_ctrl !== m_ctrl) begin
                bad++; $display("FAIL rnd_vc k=%0d got=v%0b c%0h want=v%0b c%0h", k, out_valid, out_ctrl, m_valid, m_ctrl); end
            total++; if (stall_cnt !== 16'(m_stall) || nb_stall_cnt !== 2'(m_stall_nb)) begin
                bad++; $display("FAIL rnd_stall k=%0d got=%0d/%0d want=%0d/%0d", k, stall_cnt, nb_stall_cnt, m_stall, m_stall_nb); end
            if (m_valid) begin
                total++; if (out_pc !== m_pc || out_pc_plus4 !== m_pc4 || out_rs1_addr !== m_rs1a ||
                             out_rs2_addr !== m_rs2a || out_rd_addr !== m_rd || out_illegal !== m_ill) begin
                    bad++; $display("FAIL rnd_fields k=%0d got=%0h %0h %0d %0d %0d %0b want=%0h %0h %0d %0d %0d %0b", k, out_pc, out_pc_plus4, out_rs1_addr, out_rs2_addr, out_rd_addr, out_illegal, m_pc, m_pc4, m_rs1a, m_rs2a, m_rd, m_ill); end
                total++; if (out_rs1_data !== m_rs1d || out_rs2_data !== m_rs2d || nb_out_rs1_data !== m_rs1d_nb) begin
                    bad++; $display("FAIL rnd_data k=%0d got=%0h %0h %0h want=%0h %0h %0h", k, out_rs1_data, out_rs2_data, nb_out_rs1_data, m_rs1d, m_rs2d, m_rs1d_nb); end
                if (m_has_imm) begin
                    total++; if (out_imm !== m_imm) begin
                        bad++; $display("FAIL rnd_imm k=%0d got=%0h want=%0h", k, out_imm, m_imm); end
                end
            end
        end
        idle(2);
    endtask

    task automatic test_mid_reset();
        set_in(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM), 32'h600);
        cycle();
        total++; if (out_valid !== 1'b1 || out_ctrl.reg_write !== 1'b1) begin
            bad++; $display("FAIL mrst_pre got=v%0b rw%0b want=v1 rw1", out_valid, out_ctrl.reg_write); end
        #2 rst = 1;
        #1;
        total++; if (out_valid !== 1'b0 || out_ctrl !== '0 || stall_cnt !== 16'd0 || nb_stall_cnt !== 2'd0) begin
            bad++; $display("FAIL mrst_async got=v%0b c%0h s%0d/%0d want=0", out_valid, out_ctrl, stall_cnt, nb_stall_cnt); end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        in_valid = 0;
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_after got=%0b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_bypass();
        test_backpressure_flush();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
